// File: rtl/rv_mc_ctrl.sv
`default_nettype none
// ============================================================================
// rv_mc_ctrl : RV32I multi-cycle control FSM (fetch/decode/exec/mem/wb + ERR)
// Build option ILLEGAL_TRAP_EN: illegal instructions trap to ERR instead of NOP
// Revision   : 1.0
// ============================================================================
module rv_mc_ctrl #(
   parameter int RESET_WAIT  = 2,
   parameter int ACK_TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req_o,
   input  logic        imem_ack_i,
   input  logic [31:0] imem_rdata_i,
   output logic        dmem_req_o,
   output logic        dmem_we_o,
   input  logic        dmem_ack_i,
   input  logic        br_taken_i,
   output logic [31:0] ir_o,
   output logic        alu_a_sel_o,
   output logic        alu_b_sel_o,
   output logic        rf_we_o,
   output logic [1:0]  wb_sel_o,
   output logic        pc_we_o,
   output logic [1:0]  pc_sel_o,
   output logic [2:0]  state_o,
   output logic        err_o
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_MEM    = 3'd4,
      S_WB     = 3'd5,
      S_ERR    = 3'd7
   } state_t;

   localparam int               CNT_W        = 16;
   localparam logic [CNT_W-1:0] c_WAIT_LAST  = CNT_W'(RESET_WAIT - 1);
   localparam logic [CNT_W-1:0] c_TMO_LAST   = CNT_W'(ACK_TIMEOUT - 1);
   localparam logic [31:0]      c_NOP        = 32'h0000_0013;
   localparam logic [4:0]       c_OPC_LOAD   = 5'b00000;
   localparam logic [4:0]       c_OPC_OPIMM  = 5'b00100;
   localparam logic [4:0]       c_OPC_AUIPC  = 5'b00101;
   localparam logic [4:0]       c_OPC_STORE  = 5'b01000;
   localparam logic [4:0]       c_OPC_OP     = 5'b01100;
   localparam logic [4:0]       c_OPC_LUI    = 5'b01101;
   localparam logic [4:0]       c_OPC_BRANCH = 5'b11000;
   localparam logic [4:0]       c_OPC_JALR   = 5'b11001;
   localparam logic [4:0]       c_OPC_JAL    = 5'b11011;

   state_t             state_q;
   logic [31:0]        ir_q;
   logic [CNT_W-1:0]   cnt_q;
   logic               imem_req_q, dmem_req_q, dmem_we_q;
   logic               alu_a_q, alu_b_q, rf_we_q, pc_we_q, err_q;
   logic [1:0]         wb_sel_q, pc_sel_q;

   logic [4:0] w_opc;
   logic       w_std, w_op, w_opimm, w_lui, w_auipc, w_load, w_store;
   logic       w_branch, w_jal, w_jalr, w_legal, w_rd_nz;
   logic       w_a_sel, w_b_sel, w_exec_br, w_st_done;
   logic [1:0] w_wb_sel, w_pc_sel_wb;

   assign w_opc    = ir_q[6:2];
   assign w_std    = (ir_q[1:0] == 2'b11);
   assign w_op     = w_std && (w_opc == c_OPC_OP);
   assign w_opimm  = w_std && (w_opc == c_OPC_OPIMM);
   assign w_lui    = w_std && (w_opc == c_OPC_LUI);
   assign w_auipc  = w_std && (w_opc == c_OPC_AUIPC);
   assign w_load   = w_std && (w_opc == c_OPC_LOAD);
   assign w_store  = w_std && (w_opc == c_OPC_STORE);
   assign w_branch = w_std && (w_opc == c_OPC_BRANCH);
   assign w_jal    = w_std && (w_opc == c_OPC_JAL);
   assign w_jalr   = w_std && (w_opc == c_OPC_JALR);
   assign w_legal  = w_op | w_opimm | w_lui | w_auipc | w_load | w_store |
                     w_branch | w_jal | w_jalr;
   assign w_rd_nz  = (ir_q[11:7] != 5'd0);

   // Operand selects stay stable from EXEC through MEM/WB since there is no ALU output register
   assign w_a_sel     = w_auipc | w_jal;
   assign w_b_sel     = w_opimm | w_auipc | w_load | w_store | w_jal | w_jalr;
   assign w_wb_sel    = w_lui ? 2'b11 : w_load ? 2'b01 : (w_jal | w_jalr) ? 2'b10 : 2'b00;
   assign w_pc_sel_wb = w_jal ? 2'b01 : w_jalr ? 2'b10 : 2'b00;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         ir_q       <= c_NOP;
         cnt_q      <= '0;
         imem_req_q <= 1'b0;
         dmem_req_q <= 1'b0;
         dmem_we_q  <= 1'b0;
         alu_a_q    <= 1'b0;
         alu_b_q    <= 1'b0;
         rf_we_q    <= 1'b0;
         wb_sel_q   <= 2'b00;
         pc_we_q    <= 1'b0;
         pc_sel_q   <= 2'b00;
         err_q      <= 1'b0;
      end else begin
         imem_req_q <= 1'b0;
         dmem_req_q <= 1'b0;
         dmem_we_q  <= 1'b0;
         alu_a_q    <= 1'b0;
         alu_b_q    <= 1'b0;
         rf_we_q    <= 1'b0;
         wb_sel_q   <= 2'b00;
         pc_we_q    <= 1'b0;
         pc_sel_q   <= 2'b00;
         case (state_q)
            S_IDLE: begin
               if ((RESET_WAIT == 0) || (cnt_q == c_WAIT_LAST)) begin
                  state_q    <= S_FETCH;
                  cnt_q      <= '0;
                  imem_req_q <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + 16'd1;
               end
            end
            S_FETCH: begin
               if (imem_ack_i) begin
                  ir_q    <= imem_rdata_i;
                  state_q <= S_DECODE;
               end else if ((ACK_TIMEOUT != 0) && (cnt_q == c_TMO_LAST)) begin
                  state_q <= S_ERR;
                  err_q   <= 1'b1;
               end else begin
                  cnt_q      <= cnt_q + 16'd1;
                  imem_req_q <= 1'b1;
               end
            end
            S_DECODE: begin
               if (w_legal) begin
                  state_q <= S_EXEC;
                  alu_a_q <= w_a_sel;
                  alu_b_q <= w_b_sel;
                  pc_we_q <= w_branch;
               end
`ifdef ILLEGAL_TRAP_EN
               else begin
                  state_q <= S_ERR;
                  err_q   <= 1'b1;
               end
`else
               else begin
                  state_q <= S_WB;
                  pc_we_q <= 1'b1;
               end
`endif
            end
            S_EXEC: begin
               if (w_branch) begin
                  state_q    <= S_FETCH;
                  cnt_q      <= '0;
                  imem_req_q <= 1'b1;
               end else if (w_load | w_store) begin
                  state_q    <= S_MEM;
                  cnt_q      <= '0;
                  dmem_req_q <= 1'b1;
                  dmem_we_q  <= w_store;
                  alu_a_q    <= w_a_sel;
                  alu_b_q    <= w_b_sel;
               end else begin
                  state_q  <= S_WB;
                  alu_a_q  <= w_a_sel;
                  alu_b_q  <= w_b_sel;
                  rf_we_q  <= w_rd_nz;
                  wb_sel_q <= w_wb_sel;
                  pc_we_q  <= 1'b1;
                  pc_sel_q <= w_pc_sel_wb;
               end
            end
            S_MEM: begin
               if (dmem_ack_i) begin
                  if (dmem_we_q) begin
                     state_q    <= S_FETCH;
                     cnt_q      <= '0;
                     imem_req_q <= 1'b1;
                  end else begin
                     state_q  <= S_WB;
                     alu_a_q  <= w_a_sel;
                     alu_b_q  <= w_b_sel;
                     rf_we_q  <= w_rd_nz;
                     wb_sel_q <= 2'b01;
                     pc_we_q  <= 1'b1;
                  end
               end else if ((ACK_TIMEOUT != 0) && (cnt_q == c_TMO_LAST)) begin
                  state_q <= S_ERR;
                  err_q   <= 1'b1;
               end else begin
                  cnt_q      <= cnt_q + 16'd1;
                  dmem_req_q <= 1'b1;
                  dmem_we_q  <= dmem_we_q;
                  alu_a_q    <= w_a_sel;
                  alu_b_q    <= w_b_sel;
               end
            end
            S_WB: begin
               state_q    <= S_FETCH;
               cnt_q      <= '0;
               imem_req_q <= 1'b1;
            end
            S_ERR: begin
               state_q <= S_ERR;
            end
            default: begin
               state_q <= S_ERR;
               err_q   <= 1'b1;
            end
         endcase
      end
   end

   // Branch target select and store completion depend on same-cycle inputs
   assign w_exec_br = (state_q == S_EXEC) && w_branch;
   assign w_st_done = (state_q == S_MEM) && dmem_we_q && dmem_ack_i;

   assign imem_req_o  = imem_req_q;
   assign dmem_req_o  = dmem_req_q;
   assign dmem_we_o   = dmem_we_q;
   assign ir_o        = ir_q;
   assign alu_a_sel_o = alu_a_q;
   assign alu_b_sel_o = alu_b_q;
   assign rf_we_o     = rf_we_q;
   assign wb_sel_o    = wb_sel_q;
   assign pc_we_o     = pc_we_q | w_st_done;
   assign pc_sel_o    = w_exec_br ? {1'b0, br_taken_i} : pc_sel_q;
   assign state_o     = state_q;
   assign err_o       = err_q;

endmodule
`default_nettype wire
